// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding memory read at a time, a one-entry
// output register toward decode, and redirect/flush handling from execute.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        kill_q, kill_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] redirect_tgt;

    assign redirect_tgt = {redirect_pc[31:2], 2'b00};

    always_comb begin
        // NOTE: every _d starts from its _q so no branch can infer a latch.
        state_d     = state_q;
        pc_d        = pc_q;
        kill_d      = kill_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;

        case (state_q)
            S_FETCH: begin
                if (redirect) begin
                    pc_d = redirect_tgt;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    pc_d = redirect_tgt;
                    if (imem_valid) begin
                        kill_d  = 1'b0;
                        state_d = S_FETCH;
                    end else begin
                        kill_d  = 1'b1;
                    end
                end else if (imem_valid) begin
                    if (kill_q) begin
                        // Response belongs to a flushed request; refetch from the new pc.
                        kill_d  = 1'b0;
                        state_d = S_FETCH;
                    end else begin
                        out_instr_d = imem_rdata;
                        out_pc_d    = pc_q;
                        out_valid_d = 1'b1;
                        pc_d        = pc_q + 32'd4;
                        state_d     = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    out_valid_d = 1'b0;
                    pc_d        = redirect_tgt;
                    state_d     = S_FETCH;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_FETCH;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            kill_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_instr_q <= 32'h0;
            out_pc_q    <= 32'h0;
        end else begin
            // NOTE: non-blocking so every flop updates from the same pre-edge values.
            state_q     <= state_d;
            pc_q        <= pc_d;
            kill_q      <= kill_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
        end
    end

    assign imem_req  = (state_q == S_FETCH) && !redirect && !rst;
    assign imem_addr = pc_q;
    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_pc    = out_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, hand-written corner
// sequences, and a randomized run against a transaction-level reference model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    logic        rst_w;
    logic        imem_req_w;
    logic [31:0] imem_addr_w;
    logic [31:0] imem_rdata_w;
    logic        imem_valid_w;
    logic        redirect_w;
    logic [31:0] redirect_pc_w;
    logic        out_valid_w;
    logic        out_ready_w;
    logic [31:0] out_instr_w;
    logic [31:0] out_pc_w;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_valid(imem_valid),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst(rst_w),
        .imem_req(imem_req_w), .imem_addr(imem_addr_w),
        .imem_rdata(imem_rdata_w), .imem_valid(imem_valid_w),
        .redirect(redirect_w), .redirect_pc(redirect_pc_w),
        .out_valid(out_valid_w), .out_ready(out_ready_w),
        .out_instr(out_instr_w), .out_pc(out_pc_w)
    );

    typedef struct {
        logic        rst;
        logic        iv;
        logic [31:0] rdata;
        logic        redir;
        logic [31:0] rpc;
        logic        ready;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_ov;
        logic [31:0] e_opc;
        logic [31:0] e_oi;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t row(input logic rs, input logic iv, input logic [31:0] rd,
                                 input logic rdr, input logic [31:0] rp, input logic rdy,
                                 input logic er, input logic [31:0] ea, input logic eo,
                                 input logic [31:0] ep, input logic [31:0] ei);
        vec_t v;
        v.rst = rs; v.iv = iv; v.rdata = rd; v.redir = rdr; v.rpc = rp; v.ready = rdy;
        v.e_req = er; v.e_addr = ea; v.e_ov = eo; v.e_opc = ep; v.e_oi = ei;
        return v;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'hC3A5_5A3C;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rs, input logic iv, input logic [31:0] rd,
                         input logic rdr, input logic [31:0] rp, input logic rdy);
        rst = rs; imem_valid = iv; imem_rdata = rd;
        redirect = rdr; redirect_pc = rp; out_ready = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model state for the randomized phase
    logic        m_busy, m_kill, h_v, e_req, r_rst, r_iv, r_redir, r_ready;
    logic [31:0] m_addr, h_pc, h_i, e_fetch, r_rdata, r_rpc;
    int          m_cnt;

    localparam logic [31:0] BAD = 32'hBAD0_BAD0;

    initial begin
        drive(1, 0, 0, 0, 0, 1);
        rst_w = 1'b1; imem_valid_w = 1'b0; imem_rdata_w = 32'h0;
        redirect_w = 1'b0; redirect_pc_w = 32'h0; out_ready_w = 1'b1;
        tick();

        //            rst iv rdata          rdr rpc           rdy  req addr          ov opc           oi
        tbl.push_back(row(1, 0, 32'h0,        0, 32'h0,       0,   0, 32'h0,       0, 32'h0,       32'h0));
        tbl.push_back(row(0, 0, 32'h0,        0, 32'h0,       1,   1, 32'h0,       0, 32'h0,       32'h0));
        tbl.push_back(row(0, 1, 32'h1111_0000, 0, 32'h0,      1,   0, 32'h0,       0, 32'h0,       32'h0));
        tbl.push_back(row(0, 0, 32'h0,        0, 32'h0,       1,   0, 32'h4,       1, 32'h0,       32'h1111_0000));
        tbl.push_back(row(0, 0, 32'h0,        0, 32'h0,       1,   1, 32'h4,       0, 32'h0,       32'h0));
        tbl.push_back(row(0, 1, 32'h2222_0004, 0, 32'h0,      1,   0, 32'h4,       0, 32'h0,       32'h0));
        tbl.push_back(row(0, 0, 32'h0,        0, 32'h0,       1,   0, 32'h8,       1, 32'h4,       32'h2222_0004));
        tbl.push_back(row(0, 0, 32'h0,        0, 32'h0,       1,   1, 32'h8,       0, 32'h0,       32'h0));
        tbl.push_back(row(0, 1, 32'h3333_0008, 0, 32'h0,      0,   0, 32'h8,       0, 32'h0,       32'h0));
        tbl.push_back(row(0, 0, 32'h0,        0, 32'h0,       0,   0, 32'hC,       1, 32'h8,       32'h3333_0008));
        tbl.push_back(row(0, 0, 32'h0,        0, 32'h0,       1,   0, 32'hC,       1, 32'h8,       32'h3333_0008));
        tbl.push_back(row(0, 0, 32'h0,        0, 32'h0,       1,   1, 32'hC,       0, 32'h0,       32'h0));
        tbl.push_back(row(0, 0, 32'h0,        1, 32'h100,     1,   0, 32'hC,       0, 32'h0,       32'h0));
        tbl.push_back(row(0, 1, 32'hDEAD_BEEF, 0, 32'h0,      1,   0, 32'h100,     0, 32'h0,       32'h0));
        tbl.push_back(row(0, 0, 32'h0,        0, 32'h0,       1,   1, 32'h100,     0, 32'h0,       32'h0));
        tbl.push_back(row(0, 1, 32'h4444_0100, 0, 32'h0,      1,   0, 32'h100,     0, 32'h0,       32'h0));
        tbl.push_back(row(0, 0, 32'h0,        1, 32'h203,     1,   0, 32'h104,     1, 32'h100,     32'h4444_0100));
        tbl.push_back(row(0, 0, 32'h0,        0, 32'h0,       1,   1, 32'h200,     0, 32'h0,       32'h0));
        tbl.push_back(row(0, 1, BAD,          1, 32'h40,      1,   0, 32'h200,     0, 32'h0,       32'h0));
        tbl.push_back(row(0, 0, 32'h0,        1, 32'h80,      1,   0, 32'h40,      0, 32'h0,       32'h0));
        tbl.push_back(row(0, 0, 32'h0,        0, 32'h0,       1,   1, 32'h80,      0, 32'h0,       32'h0));
        tbl.push_back(row(0, 0, 32'h0,        1, 32'h300,     1,   0, 32'h80,      0, 32'h0,       32'h0));
        tbl.push_back(row(0, 0, 32'h0,        1, 32'h404,     1,   0, 32'h300,     0, 32'h0,       32'h0));
        tbl.push_back(row(0, 1, BAD,          0, 32'h0,       1,   0, 32'h404,     0, 32'h0,       32'h0));
        tbl.push_back(row(0, 0, 32'h0,        0, 32'h0,       1,   1, 32'h404,     0, 32'h0,       32'h0));
        tbl.push_back(row(0, 1, 32'h5555_0404, 0, 32'h0,      1,   0, 32'h404,     0, 32'h0,       32'h0));
        tbl.push_back(row(0, 0, 32'h0,        0, 32'h0,       1,   0, 32'h408,     1, 32'h404,     32'h5555_0404));
        tbl.push_back(row(1, 1, BAD,          1, 32'h500,     1,   0, 32'h408,     0, 32'h0,       32'h0));
        tbl.push_back(row(0, 0, 32'h0,        0, 32'h0,       1,   1, 32'h0,       0, 32'h0,       32'h0));

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].iv, tbl[i].rdata, tbl[i].redir, tbl[i].rpc, tbl[i].ready);
            #1;
            check($sformatf("row%0d imem_req", i), 32'(imem_req), 32'(tbl[i].e_req));
            check($sformatf("row%0d imem_addr", i), imem_addr, tbl[i].e_addr);
            check($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
            if (tbl[i].e_ov) begin
                check($sformatf("row%0d out_pc", i), out_pc, tbl[i].e_opc);
                check($sformatf("row%0d out_instr", i), out_instr, tbl[i].e_oi);
            end
            tick();
        end

        // Backpressure: dut is in S_WAIT at pc 0
        drive(0, 1, 32'h6666_0000, 0, 0, 0);
        tick();
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 0, 0, 0, 0);
            #1;
            check("bp out_valid", 32'(out_valid), 32'd1);
            check("bp out_pc", out_pc, 32'h0);
            check("bp out_instr", out_instr, 32'h6666_0000);
            check("bp imem_req", 32'(imem_req), 32'd0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 1);
        #1;
        check("bp accept out_valid", 32'(out_valid), 32'd1);
        check("bp accept imem_req", 32'(imem_req), 32'd0);
        tick();
        #1;
        check("bp refetch imem_req", 32'(imem_req), 32'd1);
        check("bp refetch addr", imem_addr, 32'h4);
        check("bp refetch out_valid", 32'(out_valid), 32'd0);
        tick();

        // Reset while waiting, then a stale response right after release
        drive(1, 0, 0, 0, 0, 1);
        #1;
        check("rstwait imem_req", 32'(imem_req), 32'd0);
        tick();
        drive(0, 1, BAD, 0, 0, 1);
        #1;
        check("rstwait restart req", 32'(imem_req), 32'd1);
        check("rstwait restart addr", imem_addr, 32'h0);
        check("rstwait out_valid0", 32'(out_valid), 32'd0);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        #1;
        check("rstwait out_valid1", 32'(out_valid), 32'd0);
        check("rstwait no req", 32'(imem_req), 32'd0);
        tick();
        drive(0, 1, 32'h7777_0000, 0, 0, 1);
        tick();
        #1;
        check("rstwait deliver valid", 32'(out_valid), 32'd1);
        check("rstwait deliver pc", out_pc, 32'h0);
        check("rstwait deliver instr", out_instr, 32'h7777_0000);
        tick();

        // PC wrap on the instance reset to the top word
        tick();
        rst_w = 1'b0;
        #1;
        check("wrap first req", 32'(imem_req_w), 32'd1);
        check("wrap first addr", imem_addr_w, 32'hFFFF_FFFC);
        tick();
        imem_valid_w = 1'b1; imem_rdata_w = 32'h8888_FFFC;
        tick();
        imem_valid_w = 1'b0;
        #1;
        check("wrap out_pc", out_pc_w, 32'hFFFF_FFFC);
        check("wrap pc", imem_addr_w, 32'h0000_0000);
        tick();
        #1;
        check("wrap second req", 32'(imem_req_w), 32'd1);
        check("wrap second addr", imem_addr_w, 32'h0000_0000);

        // Randomized run against a transaction-level model
        m_busy = 0; m_kill = 0; h_v = 0; m_cnt = 0;
        m_addr = 0; h_pc = 0; h_i = 0; e_fetch = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            r_rst   = (c == 0) || ($urandom_range(0, 99) == 0);
            r_redir = ($urandom_range(0, 7) == 0);
            r_rpc   = $urandom;
            r_ready = ($urandom_range(0, 3) != 0);
            r_iv    = 1'b0;
            r_rdata = $urandom;
            if (m_busy) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    r_iv    = 1'b1;
                    r_rdata = mem_word(m_addr);
                end
            end
            drive(r_rst, r_iv, r_rdata, r_redir, r_rpc, r_ready);
            #1;
            // A request goes out whenever nothing is in flight or held and no flush is arriving.
            e_req = !r_rst && !m_busy && !h_v && !r_redir;
            check("rand imem_req", 32'(imem_req), 32'(e_req));
            if (e_req) check("rand imem_addr", imem_addr, e_fetch);
            check("rand out_valid", 32'(out_valid), 32'(h_v));
            if (h_v) begin
                check("rand out_pc", out_pc, h_pc);
                check("rand out_instr", out_instr, h_i);
            end

            if (r_rst) begin
                e_fetch = 32'h0; m_busy = 0; m_kill = 0; h_v = 0;
            end else begin
                if (e_req) begin
                    m_busy  = 1; m_kill = 0; m_addr = e_fetch;
                    m_cnt   = $urandom_range(1, 3);
                    e_fetch = e_fetch + 32'd4;
                end
                if (r_iv) begin
                    m_busy = 0;
                    if (!m_kill && !r_redir) begin
                        h_v = 1; h_pc = m_addr; h_i = r_rdata;
                    end
                end else if (h_v && r_ready) begin
                    h_v = 0;
                end
                if (r_redir) begin
                    e_fetch = {r_rpc[31:2], 2'b00};
                    if (m_busy) m_kill = 1;
                    h_v = 0;
                end
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
